deserializer_demux_param: RTL and testbench

DESERIALIZER_DEMUX_PARAM -- requirements
Module: deserializer_demux_param

---
 rtl/deserializer_demux_param.sv | 185 ++++++++++++++++++
 tb/tb_deserializer_demux_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_demux_param.sv
// ---------------------------------------------------------------------------
// deserializer_demux_param
//
// Serial-to-parallel deserializer with comma alignment and channel demux.
// Serial bits (MSB of each symbol first) are shifted in every clk_32f cycle.
// The FSM searches for the comma symbol COM at any bit offset. It then
// requires LOCK_CNT consecutive symbol-aligned commas before going ACTIVE.
// While ACTIVE, each aligned symbol is handled as follows:
//   COM   -> frame marker: channel pointer and gap counter restart at 0
//   IDL   -> one-cycle idle_det pulse, pointer unchanged
//   other -> written to channel[ptr], valid_rx[ptr] pulses, ptr advances
// If MAX_GAP consecutive non-comma symbols arrive, sync is dropped.
//
// Ports
//   clk_32f   in   bit clock, rising edge active
//   reset     in   asynchronous, active-low reset
//   data_in   in   serial data, MSB first
//   data_rx   out  NCH*WIDTH channel words, channel i at [i*WIDTH +: WIDTH]
//   valid_rx  out  NCH one-cycle update strobes, at most one set at a time
//   active    out  high while aligned and receiving
//   idle_det  out  one-cycle pulse per aligned IDL symbol while ACTIVE
// ---------------------------------------------------------------------------
module deserializer_demux_param #(
  parameter int               WIDTH    = 8,
  parameter int               NCH      = 4,
  parameter logic [WIDTH-1:0] COM      = 8'hBC,
  parameter logic [WIDTH-1:0] IDL      = 8'h7C,
  parameter int               LOCK_CNT = 4,
  parameter int               MAX_GAP  = 64
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  input  logic                 data_in,
  output logic [NCH*WIDTH-1:0] data_rx,
  output logic [NCH-1:0]       valid_rx,
  output logic                 active,
  output logic                 idle_det
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_ALIGN  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [WIDTH-1:0]     shreg_q,    shreg_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [3:0]           comma_q,    comma_d;
  logic [7:0]           gap_q,      gap_d;
  logic [PTR_W-1:0]     ptr_q,      ptr_d;
  logic [1:0]           state_q,    state_d;
  logic [NCH*WIDTH-1:0] data_q,     data_d;
  logic [NCH-1:0]       valid_q,    valid_d;
  logic                 active_q,   active_d;
  logic                 idle_q,     idle_d;

  logic                 boundary;
  logic                 is_com;
  logic                 is_idl;
  logic                 lost;
  logic [3:0]           comma_inc;
  logic [7:0]           gap_inc;

  // Decisions are made on the registered shift register contents, so a
  // symbol complete after edge k produces its outputs at edge k+1.
  assign boundary  = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign is_com    = (shreg_q == COM);
  assign is_idl    = (shreg_q == IDL);
  assign comma_inc = comma_q + 4'd1;
  assign gap_inc   = gap_q + 8'd1;

  always_comb begin
    shreg_d   = {shreg_q[WIDTH-2:0], data_in};
    bit_cnt_d = boundary ? '0 : bit_cnt_q + CNT_W'(1);
    comma_d   = comma_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = '0;
    idle_d    = 1'b0;
    lost      = 1'b0;

    case (state_q)
      S_SEARCH: begin
        // Restarting the bit counter here places the next boundary exactly
        // WIDTH cycles later, when the following symbol is complete.
        if (is_com) begin
          bit_cnt_d = '0;
          comma_d   = 4'd1;
          ptr_d     = '0;
          gap_d     = '0;
          state_d   = (LOCK_CNT == 1) ? S_ACTIVE : S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (boundary) begin
          if (is_com) begin
            comma_d = comma_inc;
            if (comma_inc == 4'(LOCK_CNT)) begin
              state_d = S_ACTIVE;
              ptr_d   = '0;
              gap_d   = '0;
            end
          end else begin
            state_d = S_SEARCH;
            comma_d = '0;
          end
        end
      end

      S_ACTIVE: begin
        if (boundary) begin
          if (is_com) begin
            ptr_d = '0;
            gap_d = '0;
          end else begin
            gap_d = gap_inc;
            if (is_idl) begin
              idle_d = 1'b1;
            end else begin
              data_d[int'(ptr_q)*WIDTH +: WIDTH] = shreg_q;
              valid_d[ptr_q]                     = 1'b1;
              ptr_d = (ptr_q == PTR_W'(NCH - 1)) ? '0 : ptr_q + PTR_W'(1);
            end
            // The symbol that exhausts the gap budget is still delivered;
            // sync is dropped afterwards.
            if (gap_inc == 8'(MAX_GAP)) begin
              state_d = S_SEARCH;
              ptr_d   = '0;
              gap_d   = '0;
              comma_d = '0;
              lost    = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = S_SEARCH;
        comma_d = '0;
        gap_d   = '0;
        ptr_d   = '0;
      end
    endcase

    // On loss of sync, active stays high for the cycle carrying the last
    // delivered symbol so valid_rx/idle_det never appear without active.
    active_d = (state_d == S_ACTIVE) || lost;
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      comma_q   <= '0;
      gap_q     <= '0;
      ptr_q     <= '0;
      state_q   <= S_SEARCH;
      data_q    <= '0;
      valid_q   <= '0;
      active_q  <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      comma_q   <= comma_d;
      gap_q     <= gap_d;
      ptr_q     <= ptr_d;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      idle_q    <= idle_d;
    end
  end

  assign data_rx  = data_q;
  assign valid_rx = valid_q;
  assign active   = active_q;
  assign idle_det = idle_q;

endmodule

// File: tb/tb_deserializer_demux_param.sv
// ---------------------------------------------------------------------------
// tb_deserializer_demux_param
//
// Drives serial symbols into deserializer_demux_param and compares every
// cycle against a symbol-level reference model, plus directed scenarios with
// hand-computed expectations (lock, misaligned start, idle, framing, loss of
// sync, reset mid-frame) and a randomized symbol-stream phase.
// ---------------------------------------------------------------------------
module tb_deserializer_demux_param;

  localparam int             WIDTH    = 8;
  localparam int             NCH      = 4;
  localparam logic [WIDTH-1:0] COM    = 8'hBC;
  localparam logic [WIDTH-1:0] IDL    = 8'h7C;
  localparam int             LOCK_CNT = 4;
  localparam int             MAX_GAP  = 64;

  logic                 clk_32f = 1'b0;
  logic                 reset   = 1'b0;
  logic                 data_in = 1'b0;
  logic [NCH*WIDTH-1:0] data_rx;
  logic [NCH-1:0]       valid_rx;
  logic                 active;
  logic                 idle_det;

  deserializer_demux_param #(
    .WIDTH(WIDTH), .NCH(NCH), .COM(COM), .IDL(IDL),
    .LOCK_CNT(LOCK_CNT), .MAX_GAP(MAX_GAP)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .data_rx (data_rx),
    .valid_rx(valid_rx),
    .active  (active),
    .idle_det(idle_det)
  );

  always #5 clk_32f = ~clk_32f;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 hunting for a comma, 1 counting aligned commas, 2 receiving.
  int                   m_mode  = 0;
  int                   m_age   = 0;   // cycles since the comma that set alignment
  int                   m_ncom  = 0;
  int                   m_gap   = 0;
  int                   m_chan  = 0;
  logic [WIDTH-1:0]     m_win   = '0;  // last WIDTH received bits
  logic [NCH*WIDTH-1:0] m_data  = '0;
  logic [NCH-1:0]       m_valid = '0;
  logic                 m_idle  = 1'b0;
  logic                 m_active = 1'b0;
  logic [WIDTH-1:0]     m_sym;
  logic                 m_bnd;
  logic                 m_lost;

  always @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_age = 0; m_ncom = 0; m_gap = 0; m_chan = 0;
      m_win = '0; m_data = '0; m_valid = '0; m_idle = 1'b0; m_active = 1'b0;
    end else begin
      m_sym   = m_win;
      m_lost  = 1'b0;
      m_valid = '0;
      m_idle  = 1'b0;
      m_age   = m_age + 1;
      m_bnd   = (m_age % WIDTH) == 0;
      if (m_mode == 0) begin
        if (m_sym == COM) begin
          m_age = 0; m_ncom = 1; m_chan = 0; m_gap = 0;
          m_mode = (LOCK_CNT == 1) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (m_bnd) begin
          if (m_sym == COM) begin
            m_ncom++;
            if (m_ncom == LOCK_CNT) begin m_mode = 2; m_chan = 0; m_gap = 0; end
          end else begin
            m_mode = 0; m_ncom = 0;
          end
        end
      end else if (m_bnd) begin
        if (m_sym == COM) begin
          m_chan = 0; m_gap = 0;
        end else begin
          m_gap++;
          if (m_sym == IDL) m_idle = 1'b1;
          else begin
            m_data[m_chan*WIDTH +: WIDTH] = m_sym;
            m_valid[m_chan] = 1'b1;
            m_chan = (m_chan + 1) % NCH;
          end
          if (m_gap == MAX_GAP) begin
            m_mode = 0; m_chan = 0; m_gap = 0; m_ncom = 0; m_lost = 1'b1;
          end
        end
      end
      m_active = (m_mode == 2) || m_lost;
      m_win    = {m_win[WIDTH-2:0], data_in};
    end
  end

  // ---------------- per-cycle compare ----------------
  bit run_cmp = 1'b0;
  int vpulses = 0;

  always @(negedge clk_32f) begin
    if (valid_rx != '0) vpulses++;
    if (run_cmp) begin
      chk("cyc_data_rx",  data_rx,  m_data);
      chk("cyc_valid_rx", valid_rx, m_valid);
      chk("cyc_active",   active,   m_active);
      chk("cyc_idle_det", idle_det, m_idle);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [NCH-1:0] snap_valid;
  logic           snap_idle, snap_active, snap_active2;

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
  endtask

  // Snapshots taken during this symbol reflect the previous symbol's outcome.
  task automatic send_sym(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == WIDTH - 2) begin
        snap_valid = valid_rx; snap_idle = idle_det; snap_active = active;
      end
      if (i == WIDTH - 3) snap_active2 = active;
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_noncom();
    logic [WIDTH-1:0] w;
    w = WIDTH'($urandom);
    if (w == COM) w = w ^ 1;
    return w;
  endfunction

  task automatic assert_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_data_rx",  data_rx,  '0);
    chk("rst_valid_rx", valid_rx, '0);
    chk("rst_active",   active,   1'b0);
    chk("rst_idle_det", idle_det, 1'b0);
    @(negedge clk_32f);
    @(negedge clk_32f);
    #2 reset = 1'b1;
  endtask

  task automatic lock4();
    repeat (4) send_sym(COM);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vp0;
    // Reset state
    repeat (3) @(negedge clk_32f);
    chk("reset_data_rx",  data_rx,  '0);
    chk("reset_valid_rx", valid_rx, '0);
    chk("reset_active",   active,   1'b0);
    chk("reset_idle_det", idle_det, 1'b0);
    run_cmp = 1'b1;
    #2 reset = 1'b1;

    // Lock then four data words into channels 0..3
    repeat (3) send_sym(COM);
    send_sym(COM);            chk("lock_not_yet",   snap_active, 1'b0);
    send_sym(8'h11);          chk("lock_active",    snap_active, 1'b1);
                              chk("lock_no_valid",  snap_valid, 4'b0000);
    send_sym(8'h22);          chk("lock_v0",        snap_valid, 4'b0001);
    send_sym(8'h33);          chk("lock_v1",        snap_valid, 4'b0010);
    send_sym(8'h44);          chk("lock_v2",        snap_valid, 4'b0100);
    send_sym(COM);            chk("lock_v3",        snap_valid, 4'b1000);
    chk("lock_data", data_rx, 32'h44332211);

    // Idle symbol between data words
    send_sym(8'h11);
    send_sym(IDL);            chk("idle_v0",   snap_valid, 4'b0001);
    send_sym(8'h22);          chk("idle_pulse", snap_idle, 1'b1);
                              chk("idle_nov",  snap_valid, 4'b0000);
    send_sym(COM);            chk("idle_v1",   snap_valid, 4'b0010);
                              chk("idle_off",  snap_idle, 1'b0);
    chk("idle_data", data_rx, 32'h44332211 & 32'hFFFF0000 | 32'h00002211);

    // Pointer wrap and frame restart
    for (int i = 1; i <= 5; i++) send_sym(WIDTH'(i));
    send_sym(COM);            chk("wrap_v0", snap_valid, 4'b0001);
    chk("wrap_data", data_rx, 32'h04030205);
    send_sym(8'h06);
    send_sym(COM);            chk("frame_v0", snap_valid, 4'b0001);
    chk("frame_data", data_rx, 32'h04030206);

    // Loss of sync after MAX_GAP non-comma words
    for (int i = 0; i < MAX_GAP - 1; i++) send_sym(rand_noncom());
    send_sym(rand_noncom());  chk("gap_still_active", snap_active, 1'b1);
    send_sym(rand_noncom());  chk("gap_last_cycle",   snap_active, 1'b1);
                              chk("gap_active_fell",  snap_active2, 1'b0);
    vp0 = vpulses;
    repeat (10) send_sym(rand_noncom());
    chk("gap_no_valid", 64'(vpulses - vp0), 64'd0);
    chk("gap_inactive", active, 1'b0);

    // Misaligned start with an aborted alignment
    @(negedge clk_32f);
    assert_reset();
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    send_sym(COM); send_sym(COM); send_sym(8'h55);
    send_sym(COM);            chk("mis_abort", snap_active, 1'b0);
    send_sym(COM); send_sym(COM); send_sym(COM);
    send_sym(8'hA0);          chk("mis_lock", snap_active, 1'b1);
    send_sym(COM);            chk("mis_v0", snap_valid, 4'b0001);
    chk("mis_data", data_rx, 32'h000000A0);

    // Reset in the middle of word 3
    send_sym(8'h11); send_sym(8'h22);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    assert_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    repeat (3) send_sym(COM);
    send_sym(8'h77);
    send_sym(8'h77);          chk("rmf_no_lock", snap_active, 1'b0);
    chk("rmf_data_zero", data_rx, '0);
    lock4();
    send_sym(8'hA5);          chk("rmf_relock", snap_active, 1'b1);
    send_sym(COM);
    chk("rmf_data", data_rx, 32'h000000A5);

    // Randomized symbol streams
    for (int r = 0; r < 40; r++) begin
      int nb;
      int ns;
      int p;
      nb = $urandom_range(0, 7);
      for (int j = 0; j < nb; j++) send_bit(1'($urandom_range(0, 1)));
      repeat (4 + $urandom_range(0, 2)) send_sym(COM);
      ns = (r % 8 == 7) ? 70 : $urandom_range(20, 60);
      for (int s = 0; s < ns; s++) begin
        p = $urandom_range(0, 99);
        if (r % 8 == 7)   send_sym(rand_noncom());
        else if (p < 10)  send_sym(COM);
        else if (p < 25)  send_sym(IDL);
        else              send_sym(rand_noncom());
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 7)) send_bit(1'($urandom_range(0, 1)));
        assert_reset();
      end
    end

    @(negedge clk_32f);
    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
